// File: rtl/morty_wb_pkg.sv
// Shared constants and state encoding for the Wishbone master arbiter.
package morty_wb_pkg;

   localparam int ARB_FIXED              = 0;
   localparam int ARB_RR                 = 1;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/morty_rr_arbiter.sv
// Combinational winner select: one-hot grant from request vector, RR pointer and mode.
module morty_rr_arbiter
   import morty_wb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int ARB_MODE    = ARB_RR,
   parameter int PTR_W       = 1
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [PTR_W-1:0]       ptr_i,
   output logic [NUM_MASTERS-1:0] gnt_o
);

   always_comb begin
      int   start;
      int   idx;
      logic found;
      gnt_o = '0;
      found = 1'b0;
      idx   = 0;
      // Fixed priority is round-robin with the search pinned to channel 0.
      start = (ARB_MODE == ARB_RR) ? int'(ptr_i) : 0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = start + i;
         if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/morty_wb_arbiter.sv
// N-channel classic Wishbone master arbiter with grant held for the whole bus cycle.
// Optional watchdog enabled by defining MORTY_WB_ARB_TIMEOUT_EN.
module morty_wb_arbiter
   import morty_wb_pkg::*;
#(
   parameter int NUM_MASTERS    = 2,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int ARB_MODE       = ARB_RR,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_addr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_dat_i,
   input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_sel_i,
   input  logic [NUM_MASTERS-1:0]                 m_we_i,
   input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
   input  logic [NUM_MASTERS-1:0]                 m_stb_i,
   output logic [DATA_WIDTH-1:0]                  m_dat_o,
   output logic [NUM_MASTERS-1:0]                 m_ack_o,
   output logic [NUM_MASTERS-1:0]                 m_err_o,
   output logic [ADDR_WIDTH-1:0]                  s_addr_o,
   output logic [DATA_WIDTH-1:0]                  s_dat_o,
   output logic [DATA_WIDTH/8-1:0]                s_sel_o,
   output logic                                   s_we_o,
   output logic                                   s_cyc_o,
   output logic                                   s_stb_o,
   input  logic [DATA_WIDTH-1:0]                  s_dat_i,
   input  logic                                   s_ack_i,
   input  logic                                   s_err_i,
   output logic [NUM_MASTERS-1:0]                 gnt_o
);

   localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int SW = DATA_WIDTH / 8;

   arb_state_t             r_state;
   logic [NUM_MASTERS-1:0] r_gnt;
   logic [PW-1:0]          r_gidx;
   logic [PW-1:0]          r_ptr;
   logic [NUM_MASTERS-1:0] w_req;
   logic [NUM_MASTERS-1:0] w_win;
   logic [PW-1:0]          w_win_idx;
   logic                   w_granted;
   logic                   w_gcyc;
   logic                   w_gstb;
   logic                   w_fire;

   assign w_req = m_cyc_i & m_stb_i;

   morty_rr_arbiter #(
      .NUM_MASTERS (NUM_MASTERS),
      .ARB_MODE    (ARB_MODE),
      .PTR_W       (PW)
   ) u_arb (
      .req_i (w_req),
      .ptr_i (r_ptr),
      .gnt_o (w_win)
   );

   always_comb begin
      w_win_idx = '0;
      for (int k = 0; k < NUM_MASTERS; k++)
         if (w_win[k]) w_win_idx = PW'(k);
   end

   assign w_granted = (r_state == ST_GRANTED);
   assign w_gcyc    = w_granted & m_cyc_i[r_gidx];
   assign w_gstb    = w_gcyc & m_stb_i[r_gidx];

`ifdef MORTY_WB_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] r_tmo;

   assign w_fire = (r_tmo == TW'(TIMEOUT_CYCLES));

   // Counts strobed cycles without a slave response; any response, release or firing restarts it.
   always_ff @(posedge clk_i) begin
      if (rst_i || !w_gcyc || s_ack_i || s_err_i || w_fire)
         r_tmo <= '0;
      else if (w_gstb)
         r_tmo <= r_tmo + TW'(1);
   end
`else
   assign w_fire = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_gidx  <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|w_req) begin
                  r_state <= ST_GRANTED;
                  r_gnt   <= w_win;
                  r_gidx  <= w_win_idx;
               end
            end
            ST_GRANTED: begin
               if (!m_cyc_i[r_gidx]) begin
                  r_state <= ST_IDLE;
                  r_gnt   <= '0;
                  r_ptr   <= (r_gidx == PW'(NUM_MASTERS - 1)) ? '0 : r_gidx + PW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign gnt_o    = r_gnt;
   assign m_dat_o  = s_dat_i;
   assign s_cyc_o  = w_gcyc & ~w_fire;
   assign s_stb_o  = w_gstb & ~w_fire;
   assign s_we_o   = w_granted & m_we_i[r_gidx];
   assign s_addr_o = w_granted ? m_addr_i[r_gidx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign s_dat_o  = w_granted ? m_dat_i[r_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign s_sel_o  = w_granted ? m_sel_i[r_gidx*SW +: SW] : '0;

   // Responses reach only the owner of the grant; anything seen while idle is dropped.
   always_comb begin
      m_ack_o = '0;
      m_err_o = '0;
      if (w_granted) begin
         m_ack_o[r_gidx] = s_ack_i;
         m_err_o[r_gidx] = s_err_i | w_fire;
      end
   end

endmodule

// File: tb/tb_morty_wb_arbiter.sv
// Directed scoreboard bench: a round-robin and a fixed-priority instance share the stimulus.
// Timeout rows are included when MORTY_WB_ARB_TIMEOUT_EN is defined.
module tb_morty_wb_arbiter;

   typedef struct {
      bit          sel;
      bit          rst;
      bit          chk;
      logic [1:0]  cyc;
      logic [1:0]  stb;
      logic        ack;
      logic        err;
      logic [31:0] sdat;
      logic [1:0]  egnt;
      logic        escyc;
      logic [1:0]  eack;
      logic [1:0]  eerr;
   } row_t;

   typedef struct {
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [31:0] dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [63:0] m_addr = {32'h0000_0200, 32'h0000_0100};
   logic [63:0] m_dat  = {32'hB1B1_0000, 32'hA0A0_0000};
   logic [7:0]  m_sel  = 8'hFF;
   logic [1:0]  m_we   = 2'b10;
   logic [1:0]  m_cyc  = 2'b00;
   logic [1:0]  m_stb  = 2'b00;
   logic [31:0] s_dat  = 32'h0;
   logic        s_ack  = 1'b0;
   logic        s_err  = 1'b0;
   bit          sel    = 1'b0;

   logic [31:0] rr_mdat, fx_mdat, rr_sdat, fx_sdat, rr_saddr, fx_saddr;
   logic [1:0]  rr_ack, fx_ack, rr_err, fx_err, rr_gnt, fx_gnt;
   logic [3:0]  rr_ssel, fx_ssel;
   logic        rr_we, fx_we, rr_cyc, fx_cyc, rr_stb, fx_stb;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   row_t rows[$];

   always #5 clk = ~clk;

   morty_wb_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .ARB_MODE(1), .TIMEOUT_CYCLES(4)) u_rr (
      .clk_i(clk), .rst_i(rst), .m_addr_i(m_addr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_dat_o(rr_mdat),
      .m_ack_o(rr_ack), .m_err_o(rr_err), .s_addr_o(rr_saddr), .s_dat_o(rr_sdat),
      .s_sel_o(rr_ssel), .s_we_o(rr_we), .s_cyc_o(rr_cyc), .s_stb_o(rr_stb),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(rr_gnt));

   morty_wb_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                      .ARB_MODE(0), .TIMEOUT_CYCLES(4)) u_fx (
      .clk_i(clk), .rst_i(rst), .m_addr_i(m_addr), .m_dat_i(m_dat), .m_sel_i(m_sel),
      .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_dat_o(fx_mdat),
      .m_ack_o(fx_ack), .m_err_o(fx_err), .s_addr_o(fx_saddr), .s_dat_o(fx_sdat),
      .s_sel_o(fx_ssel), .s_we_o(fx_we), .s_cyc_o(fx_cyc), .s_stb_o(fx_stb),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .gnt_o(fx_gnt));

   wire [1:0]  w_ack  = sel ? fx_ack   : rr_ack;
   wire [1:0]  w_err  = sel ? fx_err   : rr_err;
   wire [1:0]  w_gnt  = sel ? fx_gnt   : rr_gnt;
   wire        w_cyc  = sel ? fx_cyc   : rr_cyc;
   wire        w_we   = sel ? fx_we    : rr_we;
   wire [31:0] w_addr = sel ? fx_saddr : rr_saddr;
   wire [31:0] w_mdat = sel ? fx_mdat  : rr_mdat;

   function automatic row_t r(bit sl, bit rs, bit ck, logic [1:0] cy, logic [1:0] sb,
                              logic ak, logic er, logic [31:0] sd, logic [1:0] eg,
                              logic ec, logic [1:0] ea, logic [1:0] ee);
      row_t x;
      x.sel = sl; x.rst = rs; x.chk = ck; x.cyc = cy; x.stb = sb; x.ack = ak; x.err = er;
      x.sdat = sd; x.egnt = eg; x.escyc = ec; x.eack = ea; x.eerr = ee;
      return x;
   endfunction

   // Monitor: every response the selected DUT presents must match the oldest expectation.
   always @(negedge clk) begin
      if ((|w_ack) || (|w_err)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected ack=%b err=%b want none", w_ack, w_err);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (w_ack !== e.ack || w_err !== e.err || w_mdat !== e.dat) begin
               errors++;
               $display("FAIL resp ack=%b err=%b dat=%h want ack=%b err=%b dat=%h",
                        w_ack, w_err, w_mdat, e.ack, e.err, e.dat);
            end
         end
      end
   end

   initial begin
      // reset
      rows.push_back(r(0,1,0,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,1,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      // single ch0 read, slave acks two cycles after request
      rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b01,1,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b01,2'b01,1,0,32'hCAFE_0100,2'b01,1,2'b01,2'b00));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b01,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      // round-robin alternation
      rows.push_back(r(0,1,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      for (int i = 0; i < 2; i++) begin
         rows.push_back(r(0,0,1,2'b11,2'b11,0,0,32'h0,2'b00,0,2'b00,2'b00));
         rows.push_back(r(0,0,1,2'b11,2'b11,1,0,32'h1000_0000 + i,2'b01,1,2'b01,2'b00));
         rows.push_back(r(0,0,1,2'b10,2'b10,0,0,32'h0,2'b01,0,2'b00,2'b00));
         rows.push_back(r(0,0,1,2'b11,2'b11,0,0,32'h0,2'b00,0,2'b00,2'b00));
         rows.push_back(r(0,0,1,2'b11,2'b11,1,0,32'h2000_0000 + i,2'b10,1,2'b10,2'b00));
         rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b10,0,2'b00,2'b00));
      end
      // ch1 multi-beat with stb gaps; ch0 waits; ack+err together; idle responses dropped
      rows.push_back(r(0,1,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b10,2'b10,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b11,2'b11,1,0,32'h4444_0001,2'b10,1,2'b10,2'b00));
      rows.push_back(r(0,0,1,2'b11,2'b01,0,0,32'h0,2'b10,1,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b11,2'b11,1,0,32'h4444_0002,2'b10,1,2'b10,2'b00));
      rows.push_back(r(0,0,1,2'b11,2'b01,0,0,32'h0,2'b10,1,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b11,2'b11,1,1,32'h4444_0003,2'b10,1,2'b10,2'b10));
      rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b10,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b01,2'b01,1,1,32'hDEAD_0000,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b01,2'b01,1,0,32'h4444_0004,2'b01,1,2'b01,2'b00));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b01,0,2'b00,2'b00));
      // reset while granted with the slave ack arriving afterwards
      rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,1,1,2'b01,2'b01,0,0,32'h0,2'b01,1,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b01,2'b01,1,0,32'h5555_0000,2'b00,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b01,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
`ifdef MORTY_WB_ARB_TIMEOUT_EN
      // slave never answers: error after four stalled strobe cycles
      rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b00,0,2'b00,2'b00));
      for (int i = 0; i < 4; i++)
         rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h0,2'b01,1,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b01,2'b01,0,0,32'h7777_0000,2'b01,0,2'b00,2'b01));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b01,0,2'b00,2'b00));
      rows.push_back(r(0,0,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
`endif
      // fixed priority: ch0 wins every arbitration while it asks
      rows.push_back(r(1,1,0,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(1,1,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));
      for (int i = 0; i < 2; i++) begin
         rows.push_back(r(1,0,1,2'b11,2'b11,0,0,32'h0,2'b00,0,2'b00,2'b00));
         rows.push_back(r(1,0,1,2'b11,2'b11,1,0,32'h6000_0000 + i,2'b01,1,2'b01,2'b00));
         rows.push_back(r(1,0,1,2'b10,2'b10,0,0,32'h0,2'b01,0,2'b00,2'b00));
      end
      rows.push_back(r(1,0,1,2'b10,2'b10,0,0,32'h0,2'b00,0,2'b00,2'b00));
      rows.push_back(r(1,0,1,2'b10,2'b10,1,0,32'h6000_00FF,2'b10,1,2'b10,2'b00));
      rows.push_back(r(1,0,1,2'b00,2'b00,0,0,32'h0,2'b10,0,2'b00,2'b00));
      rows.push_back(r(1,0,1,2'b00,2'b00,0,0,32'h0,2'b00,0,2'b00,2'b00));

      foreach (rows[n]) begin
         @(posedge clk);
         #1;
         sel   = rows[n].sel;
         rst   = rows[n].rst;
         m_cyc = rows[n].cyc;
         m_stb = rows[n].stb;
         s_ack = rows[n].ack;
         s_err = rows[n].err;
         s_dat = rows[n].sdat;
         if ((|rows[n].eack) || (|rows[n].eerr)) begin
            exp_t e;
            e.ack = rows[n].eack;
            e.err = rows[n].eerr;
            e.dat = rows[n].sdat;
            exp_q.push_back(e);
         end
         @(negedge clk);
         if (rows[n].chk) begin
            checks++;
            if (w_gnt !== rows[n].egnt || w_cyc !== rows[n].escyc) begin
               errors++;
               $display("FAIL grant row%0d gnt=%b cyc=%b want gnt=%b cyc=%b",
                        n, w_gnt, w_cyc, rows[n].egnt, rows[n].escyc);
            end
            if (rows[n].escyc) begin
               logic [31:0] ea;
               ea = rows[n].egnt[1] ? 32'h0000_0200 : 32'h0000_0100;
               checks++;
               if (w_addr !== ea || w_we !== rows[n].egnt[1]) begin
                  errors++;
                  $display("FAIL route row%0d addr=%h we=%b want addr=%h we=%b",
                           n, w_addr, w_we, ea, rows[n].egnt[1]);
               end
            end
         end
      end

      @(posedge clk);
      #1;
      rst = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0; s_err = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL resp_missing pending=%0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
